// File: rtl/serial_arith_pkg.sv
// Shared definitions for bit-serial arithmetic controllers.
package serial_arith_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } ser_state_e;

endpackage

// File: rtl/fs_cell.sv
// One-bit full subtractor: d = a - b - bin, bout is the borrow out.
module fs_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor: one fs_cell evaluated per cycle, LSB first, over WIDTH RUN cycles.
module serial_sub_ctrl
  import serial_arith_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  ser_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic            borrow_q, borrow_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            cell_d, cell_bout;

  fs_cell u_fs_cell (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .bin  (borrow_q),
    .d    (cell_d),
    .bout (cell_bout)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    busy_d   = busy_q;
    done_d   = done_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d  = StRun;
          a_sh_d   = a;
          b_sh_d   = b;
          borrow_d = 1'b0;
          cnt_d    = '0;
          busy_d   = 1'b1;
        end
      end
      StRun: begin
        // Result bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
        diff_d   = {cell_d, diff_q[WIDTH-1:1]};
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        borrow_d = cell_bout;
        if (cnt_q == CntLast) begin
          state_d = StDone;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
        done_d  = 1'b0;
      end
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign diff       = diff_q;
  assign borrow_out = borrow_q;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Directed and random checks of serial_sub_ctrl at WIDTH=8.
module tb_serial_sub_ctrl;

  localparam int unsigned WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;

  int vectors;
  int miscompares;
  bit mon_en;

  serial_sub_ctrl #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (mon_en) begin
      vectors++;
      assert (!(busy && done)) else begin
        miscompares++;
        $error("FAIL busy_done_overlap: observed busy=%0b done=%0b, required not both high",
               busy, done);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Full operation with exact latency checks; glitch_at > 0 pulses a stray start in that RUN cycle.
  task automatic op(input logic [7:0] av, input logic [7:0] bv, input logic [7:0] ed,
                    input logic eb, input int glitch_at);
    int busy_cnt;
    a = av;
    b = bv;
    start = 1'b1;
    tick();
    start = 1'b0;
    a = ~av;
    b = ~bv;
    busy_cnt = 0;
    for (int i = 1; i <= int'(WIDTH); i++) begin
      if (busy === 1'b1) busy_cnt++;
      check("no_done_in_run", {31'd0, done}, 32'd0);
      if (i == glitch_at) begin
        start = 1'b1;
        a = 8'h01;
        b = 8'h01;
      end
      tick();
      start = 1'b0;
    end
    check("busy_cycles", busy_cnt, WIDTH);
    check("done_pulse", {31'd0, done}, 32'd1);
    check("busy_in_done", {31'd0, busy}, 32'd0);
    check("diff", {24'd0, diff}, {24'd0, ed});
    check("borrow_out", {31'd0, borrow_out}, {31'd0, eb});
    tick();
    check("done_one_cycle", {31'd0, done}, 32'd0);
    check("idle_not_busy", {31'd0, busy}, 32'd0);
    check("diff_hold_idle", {24'd0, diff}, {24'd0, ed});
  endtask

  initial begin
    logic [7:0] ra, rb;
    logic [8:0] exp9;
    int         wait_cnt;
    vectors = 0;
    miscompares = 0;
    mon_en = 1'b0;
    rst = 1'b1;
    start = 1'b1;
    a = 8'hAA;
    b = 8'h55;
    tick();
    tick();
    mon_en = 1'b1;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_diff", {24'd0, diff}, 32'd0);
    check("reset_borrow", {31'd0, borrow_out}, 32'd0);
    rst = 1'b0;
    start = 1'b0;
    tick();

    op(8'h5A, 8'h3C, 8'h1E, 1'b0, 0);
    op(8'h00, 8'h01, 8'hFF, 1'b1, 0);
    op(8'hFF, 8'hFF, 8'h00, 1'b0, 0);
    op(8'h80, 8'h7F, 8'h01, 1'b0, 0);

    // Several idle cycles with changing operands must not disturb the held result.
    for (int i = 0; i < 3; i++) begin
      a = 8'(i * 37);
      b = 8'(i * 11);
      tick();
      check("idle_stable_diff", {24'd0, diff}, 32'h01);
      check("idle_stable_busy", {31'd0, busy}, 32'd0);
    end

    op(8'h10, 8'h20, 8'hF0, 1'b1, 3);

    // Abort mid-RUN with reset.
    a = 8'h5A;
    b = 8'h3C;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i < 4; i++) tick();
    check("run_before_abort", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_diff", {24'd0, diff}, 32'd0);
    check("abort_borrow", {31'd0, borrow_out}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("abort_no_done", {31'd0, done}, 32'd0);
    end
    op(8'h05, 8'h03, 8'h02, 1'b0, 0);

    for (int n = 0; n < 1000; n++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      exp9 = {1'b0, ra} - {1'b0, rb};
      a = ra;
      b = rb;
      start = 1'b1;
      tick();
      start = 1'b0;
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      wait_cnt = 0;
      while (done !== 1'b1 && wait_cnt < 20) begin
        tick();
        wait_cnt++;
      end
      check("rand_latency", wait_cnt, WIDTH);
      check("rand_result", {23'd0, borrow_out, diff}, {23'd0, (ra < rb), exp9[7:0]});
      tick();
    end

    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
